hazard_control: RTL and testbench
=================================

# hazard_control

Pipeline sequencing controller for the five-stage RISC-V core. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Each cycle it resolves load-use hazards, taken-branch redirects, instruction-memory wait states and data-memory wait states. It also keeps a pending-discard flag for redirects that overlap an outstanding fetch, plus saturating stall and flush counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs1  in  5  rs1 field of the instruction in ID
- id_rs2  in  5  rs2 field of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- imem_ready  in  1  instruction memory returns valid data this cycle
- dmem_req  in  1  MEM stage has a load or store in flight
- dmem_ready  in  1  data memory completes the access this cycle
- cnt_clear  in  1  synchronous clear of both counters
- pc_write  out  1  PC register update enable
- if_id_write  out  1  IF/ID update enable
- if_id_flush  out  1  IF/ID loads zero (NOP)
- id_ex_flush  out  1  ID/EX loads a bubble
- ex_mem_write  out  1  EX/MEM update enable; also enables ID/EX and MEM/WB
- mem_hold  out  1  registered; high while the FSM is in MEM_HOLD
- stall_count  out  CNT_W  cycles with pc_write=0
- flush_count  out  CNT_W  accepted taken-branch redirects

## Operation
- The control outputs are combinational from the current inputs, the FSM state and discard_pending.
- The events below are evaluated in priority order. The first matching event sets the outputs. Every output not listed takes its default.
- Defaults: pc_write=1, if_id_write=1, ex_mem_write=1, all flushes 0.
- Definition: load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).

Events, highest priority first:
1. **freeze** (dmem_req & !dmem_ready):
   - pc_write=0, if_id_write=0, ex_mem_write=0, no flushes.
   - ex_branch_taken, load_use and imem_ready are ignored. EX is held, so the branch is presented again later.
2. **redirect** (ex_branch_taken):
   - pc_write=1, if_id_flush=1, id_ex_flush=1.
   - If imem_ready=0 in this cycle, set discard_pending.
3. **load_use**:
   - pc_write=0, if_id_write=0, id_ex_flush=1. This inserts exactly one bubble.
4. **fetch wait** (!imem_ready):
   - pc_write=0, if_id_flush=1. A NOP enters ID and downstream stages advance.
5. **discard** (discard_pending & imem_ready):
   - if_id_flush=1 and clear discard_pending. The stale instruction is dropped.
   - pc_write=1, so the next fetch from the redirect target proceeds.

FSM, two states:
- RUN -> MEM_HOLD when freeze is true.
- MEM_HOLD -> RUN on the first cycle with dmem_ready=1. That cycle is not a freeze, and normal evaluation applies.
- MEM_HOLD persists while dmem_req & !dmem_ready. If dmem_req drops without dmem_ready, the FSM returns to RUN.

discard_pending:
- Set as described in event 2. Cleared only by event 5.
- Retained across freeze cycles.
- A new redirect while already pending leaves it set.

Counters:
- stall_count increments on every cycle with pc_write=0, including freeze cycles.
- flush_count increments on every cycle in which event 2 fires.
- Both counters saturate at all-ones.
- cnt_clear zeroes both counters and has priority over an increment in the same cycle.

## Timing
- Hazard controls take effect in the cycle the condition is present, with zero latency.
- mem_hold asserts one cycle after the first freeze cycle and deasserts one cycle after dmem_ready.
- Reset asserted (reset=0), which applies asynchronously:
  - state=RUN, mem_hold=0, discard_pending=0, counters=0.
  - Control outputs forced to pc_write=0, if_id_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_write=1, so the pipeline fills with bubbles.
  - Counters do not count while reset is asserted.
- Reset released: the first rising edge evaluates normally.
- Reset mid-freeze or mid-discard abandons all pending state.

## Structure
- A shared package core_ctrl_pkg holds the FSM state enum (RUN, MEM_HOLD), the x0 register index constant and the default CNT_W.
- One natural sub-module: perf_counter, a saturating counter with increment and clear inputs, instantiated twice.
- Hazard priority logic stays flat in hazard_control.

## Test plan
- **Load-use hazard:** ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1, stall_count 0->1. Repeat with ex_rd=0 -> no stall.
- **Simultaneous branch and load-use:** ex_branch_taken=1 and load_use true together -> redirect wins: pc_write=1, both flushes 1, flush_count +1, stall_count unchanged.
- **Data-memory freeze:** dmem_req=1, dmem_ready=0 for 3 cycles with ex_branch_taken=1 held -> all enables 0, no flushes, flush_count unchanged, mem_hold high cycles 2-4, stall_count +3. dmem_ready=1 then completes the redirect with flush_count +1.
- **Redirect over outstanding fetch:** ex_branch_taken=1 with imem_ready=0, then 2 idle cycles, then imem_ready=1 -> if_id_flush=1 on the imem_ready cycle and discard_pending clears. The next imem_ready fetch is accepted without a flush.
- **Counter saturation and clear:** with CNT_W=4, hold fetch wait for 20 cycles -> stall_count=15. Then assert cnt_clear in the same cycle as a stall -> stall_count=0.
- **Reset mid-freeze:** assert reset=0 during MEM_HOLD with discard_pending=1 -> immediately mem_hold=0, counters=0, pc_write=0, both flushes 1. After release, the FSM is in RUN with no discard.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM states,
// the x0 register index and the default performance-counter width.
package core_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_HOLD = 1'b1
  } state_t;

  localparam logic [4:0]  REG_X0        = 5'd0;
  localparam int unsigned CNT_W_DEFAULT = 32;

endpackage

// File: rtl/hazard_control_if.sv
// Bundle of hazard inputs and pipeline controls exchanged between the
// sequencing controller (master) and the pipeline datapath (slave).
interface hazard_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             cnt_clear;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_hold;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, imem_ready, dmem_req, dmem_ready, cnt_clear,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
           mem_hold, stall_count, flush_count
  );

  modport slave (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, imem_ready, dmem_req, dmem_ready, cnt_clear,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
           mem_hold, stall_count, flush_count
  );
endinterface

// File: rtl/perf_counter.sv
// Saturating event counter with synchronous clear taking priority over
// increment.
module perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Five-stage pipeline sequencing controller: prioritised hazard resolution,
// data-memory hold FSM, redirect discard tracking and performance counters.
module hazard_control
  import core_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_t state;
  logic   discard_pending;
  logic   load_use;
  logic   freeze;
  logic   redirect;
  logic   discard;

  assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  assign freeze   = dmem_req && !dmem_ready;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    redirect     = 1'b0;
    discard      = 1'b0;
    if (!reset) begin
      // Bubbles flow through the pipeline while reset is held.
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (ex_branch_taken) begin
      redirect    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end else if (discard_pending) begin
      discard     = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  // The hold state tracks freeze directly: it persists while the access is
  // outstanding and drops on completion or when the request goes away.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= RUN;
      discard_pending <= 1'b0;
    end else begin
      state <= freeze ? MEM_HOLD : RUN;
      if (redirect && !imem_ready) begin
        discard_pending <= 1'b1;
      end else if (discard) begin
        discard_pending <= 1'b0;
      end
    end
  end

  assign mem_hold = (state == MEM_HOLD);

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (!pc_write),
    .count (stall_count)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (redirect),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Randomised and directed checking of hazard_control against a
// cycle-level behavioural model of the sequencing rules.
module tb_hazard_control;

  localparam int unsigned W   = 4;
  localparam int          SAT = (1 << W) - 1;

  logic clock;
  logic reset;

  hazard_control_if #(.CNT_W(W)) bus ();

  hazard_control #(.CNT_W(W)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs1          (bus.id_rs1),
    .id_rs2          (bus.id_rs2),
    .id_use_rs1      (bus.id_use_rs1),
    .id_use_rs2      (bus.id_use_rs2),
    .ex_rd           (bus.ex_rd),
    .ex_mem_read     (bus.ex_mem_read),
    .ex_branch_taken (bus.ex_branch_taken),
    .imem_ready      (bus.imem_ready),
    .dmem_req        (bus.dmem_req),
    .dmem_ready      (bus.dmem_ready),
    .cnt_clear       (bus.cnt_clear),
    .pc_write        (bus.pc_write),
    .if_id_write     (bus.if_id_write),
    .if_id_flush     (bus.if_id_flush),
    .id_ex_flush     (bus.id_ex_flush),
    .ex_mem_write    (bus.ex_mem_write),
    .mem_hold        (bus.mem_hold),
    .stall_count     (bus.stall_count),
    .flush_count     (bus.flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state
  bit m_pend;
  bit m_hold;
  int m_stall;
  int m_flush;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend  = 0;
    m_hold  = 0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  // Returns {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write};
  // ev names the rule that fired (0 = none).
  function automatic logic [4:0] model_ctrl(output int ev);
    bit lu;
    lu = bus.ex_mem_read && bus.ex_rd != 0 &&
         ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
          (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    ev = 0;
    if (!reset)                              return 5'b01111;
    if (bus.dmem_req && !bus.dmem_ready) begin ev = 1; return 5'b00000; end
    if (bus.ex_branch_taken)             begin ev = 2; return 5'b11111; end
    if (lu)                              begin ev = 3; return 5'b00011; end
    if (!bus.imem_ready)                 begin ev = 4; return 5'b01101; end
    if (m_pend)                          begin ev = 5; return 5'b11101; end
    return 5'b11001;
  endfunction

  function automatic logic [4:0] dut_ctrl();
    return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_write};
  endfunction

  task automatic check_all(input logic [4:0] e);
    check_eq("ctrl", dut_ctrl(), e);
    check_eq("mem_hold", bus.mem_hold, m_hold);
    check_eq("stall_count", bus.stall_count, m_stall);
    check_eq("flush_count", bus.flush_count, m_flush);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    int ev;
    logic [4:0] e;
    bit clr;
    e = model_ctrl(ev);
    clr = bus.cnt_clear;
    #1;
    check_all(e);
    @(posedge clock);
    if (reset) begin
      m_hold = (ev == 1);
      if (ev == 2 && !bus.imem_ready) m_pend = 1;
      if (ev == 5) m_pend = 0;
      if (clr) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (!e[4] && m_stall < SAT) m_stall++;
        if (ev == 2 && m_flush < SAT) m_flush++;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_mem_read = 1'b0;
    bus.ex_branch_taken = 1'b0; bus.imem_ready = 1'b1;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    bus.cnt_clear = 1'b0;
  endtask

  task automatic randomize_inputs();
    bus.id_rs1          = 5'($urandom_range(0, 3));
    bus.id_rs2          = 5'($urandom_range(0, 3));
    bus.id_use_rs1      = 1'($urandom_range(0, 1));
    bus.id_use_rs2      = 1'($urandom_range(0, 1));
    bus.ex_rd           = 5'($urandom_range(0, 3));
    bus.ex_mem_read     = 1'($urandom_range(0, 1));
    bus.ex_branch_taken = ($urandom_range(0, 3) == 0);
    bus.imem_ready      = ($urandom_range(0, 9) < 7);
    bus.dmem_req        = ($urandom_range(0, 2) == 0);
    bus.dmem_ready      = 1'($urandom_range(0, 1));
    bus.cnt_clear       = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clock);
    #1 check_all(5'b01111);
    reset = 1'b1;

    // Load-use, then same pattern on x0
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
    tick();
    bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    tick();

    // Branch together with load-use
    bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.ex_branch_taken = 1'b1;
    tick();
    idle();

    // Freeze with a held branch, then completion
    bus.ex_branch_taken = 1'b1; bus.dmem_req = 1'b1;
    repeat (3) tick();
    bus.dmem_ready = 1'b1;
    tick();
    idle();
    tick();

    // Redirect over outstanding fetch, two waits, then the stale fetch
    bus.ex_branch_taken = 1'b1; bus.imem_ready = 1'b0;
    tick();
    bus.ex_branch_taken = 1'b0;
    repeat (2) tick();
    bus.imem_ready = 1'b1;
    #1 check_eq("discard_flush", bus.if_id_flush, 1'b1);
    tick();
    tick();

    // Saturation of stall_count, then clear beating a stall
    bus.cnt_clear = 1'b1; tick(); bus.cnt_clear = 1'b0;
    bus.imem_ready = 1'b0;
    repeat (20) tick();
    check_eq("stall_sat", bus.stall_count, SAT);
    bus.cnt_clear = 1'b1;
    tick();
    check_eq("stall_clear", bus.stall_count, 0);
    idle();

    // Reset during a hold with a discard pending
    bus.ex_branch_taken = 1'b1; bus.imem_ready = 1'b0;
    tick();
    bus.ex_branch_taken = 1'b0; bus.dmem_req = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b0;
    model_reset();
    #1 check_all(5'b01111);
    @(posedge clock);
    #1 check_all(5'b01111);
    @(negedge clock);
    reset = 1'b1;
    idle();
    #1 check_eq("no_discard", dut_ctrl(), 5'b11001);
    tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
